// File: rtl/dbg_trace_tx.sv
// dbg_trace_tx: frames snapshots of the six debug outputs into a 9-byte valid/ready byte stream
// clk/rst: clock and async active-low reset
// output_en + pc_out..mem_data_out: sample request and the debug values it captures
// tx_data/tx_valid/tx_ready: byte stream SYNC, SEQ, six payload bytes, CSUM
// frame_start/busy/drop_count: SYNC flag, frame in flight, saturating missed-request count
module dbg_trace_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              output_en,
  input  logic [7:0]        pc_out,
  input  logic [7:0]        instr_out,
  input  logic [7:0]        alu_out,
  input  logic [7:0]        reg_x1,
  input  logic [7:0]        reg_x2,
  input  logic [7:0]        mem_data_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              frame_start,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count
);
  typedef enum logic [2:0] {IDLE, SYNC, SEQ, PAYLOAD, CSUM} state_t;
  state_t state;
  logic [2:0] idx;
  logic [7:0] seq;
  logic [7:0] snap [6];
  logic [7:0] csum;
  logic hs, last, cap;
  assign hs = tx_valid & tx_ready;
  assign last = (state == CSUM) & hs;
  // a request on the closing CSUM handshake chains straight into the next frame
  assign cap = output_en & ((state == IDLE) | last);
  assign csum = seq ^ snap[0] ^ snap[1] ^ snap[2] ^ snap[3] ^ snap[4] ^ snap[5];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      seq <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      frame_start <= 1'b0;
      busy <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < 6; i++) snap[i] <= '0;
    end else begin
      if (output_en && state != IDLE && !last && drop_count != '1)
        drop_count <= drop_count + DROP_W'(1);
      if (last) seq <= seq + 8'd1;
      if (cap) begin
        snap[0] <= pc_out;
        snap[1] <= instr_out;
        snap[2] <= alu_out;
        snap[3] <= reg_x1;
        snap[4] <= reg_x2;
        snap[5] <= mem_data_out;
        state <= SYNC;
        tx_data <= SYNC_BYTE;
        tx_valid <= 1'b1;
        frame_start <= 1'b1;
        busy <= 1'b1;
      end else if (hs) begin
        frame_start <= 1'b0;
        case (state)
          SYNC: begin
            state <= SEQ;
            tx_data <= seq;
          end
          SEQ: begin
            state <= PAYLOAD;
            idx <= '0;
            tx_data <= snap[0];
          end
          PAYLOAD: begin
            state <= (idx == 3'd5) ? CSUM : PAYLOAD;
            idx <= (idx == 3'd5) ? idx : idx + 3'd1;
            tx_data <= (idx == 3'd5) ? csum : snap[idx + 3'd1];
          end
          default: begin
            state <= IDLE;
            tx_data <= '0;
            tx_valid <= 1'b0;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dbg_trace_tx.sv
// tb_dbg_trace_tx: scoreboard bench for dbg_trace_tx
module tb_dbg_trace_tx;
  logic clk = 0, rst = 0, output_en = 0, tx_ready = 1;
  logic [7:0] pc_out = 0, instr_out = 0, alu_out = 0, reg_x1 = 0, reg_x2 = 0, mem_data_out = 0;
  logic [7:0] tx_data, s_data;
  logic tx_valid, frame_start, busy, s_valid, s_fs, s_busy;
  logic [7:0] drop_count;
  logic [3:0] s_drop;
  int total = 0, bad = 0;
  logic [8:0] q [$];
  logic [7:0] exp_seq = 0;
  always #5 clk = ~clk;
  dbg_trace_tx dut (
    .clk(clk), .rst(rst), .output_en(output_en), .pc_out(pc_out), .instr_out(instr_out),
    .alu_out(alu_out), .reg_x1(reg_x1), .reg_x2(reg_x2), .mem_data_out(mem_data_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .frame_start(frame_start),
    .busy(busy), .drop_count(drop_count)
  );
  dbg_trace_tx #(.DROP_W(4)) u_sat (
    .clk(clk), .rst(rst), .output_en(output_en), .pc_out(pc_out), .instr_out(instr_out),
    .alu_out(alu_out), .reg_x1(reg_x1), .reg_x2(reg_x2), .mem_data_out(mem_data_out),
    .tx_data(s_data), .tx_valid(s_valid), .tx_ready(tx_ready), .frame_start(s_fs),
    .busy(s_busy), .drop_count(s_drop)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic push_frame(input logic [7:0] p, i, a, x1, x2, m);
    logic [7:0] cs;
    cs = exp_seq ^ p ^ i ^ a ^ x1 ^ x2 ^ m;
    q.push_back({1'b1, 8'hA5});
    q.push_back({1'b0, exp_seq});
    q.push_back({1'b0, p});
    q.push_back({1'b0, i});
    q.push_back({1'b0, a});
    q.push_back({1'b0, x1});
    q.push_back({1'b0, x2});
    q.push_back({1'b0, m});
    q.push_back({1'b0, cs});
    exp_seq = exp_seq + 8'd1;
  endtask
  task automatic set_in(input logic [7:0] p, i, a, x1, x2, m);
    pc_out = p; instr_out = i; alu_out = a; reg_x1 = x1; reg_x2 = x2; mem_data_out = m;
  endtask
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (busy) chk("idle timeout", busy, 0);
  endtask
  // mode 0: ready held high, 1: random ready with a 5-cycle stall on byte 13, 2: pc changes mid-frame
  task automatic send(input logic [7:0] p, i, a, x1, x2, m, input int mode, output int cyc);
    bit stalled;
    stalled = 0;
    push_frame(p, i, a, x1, x2, m);
    set_in(p, i, a, x1, x2, m);
    output_en = 1;
    @(posedge clk); #1;
    output_en = 0;
    cyc = 0;
    while (busy && cyc < 300) begin
      if (mode == 1) begin
        if (!stalled && tx_data == 8'h13) begin
          tx_ready = 0;
          repeat (5) begin
            @(posedge clk); #1;
            chk("stall hold", {tx_valid, tx_data}, {1'b1, 8'h13});
            cyc++;
          end
          stalled = 1;
        end
        tx_ready = 1'($urandom_range(0, 1));
      end
      if (mode == 2 && cyc == 5) pc_out = 8'h44;
      @(posedge clk); #1;
      cyc++;
    end
    if (busy) chk("frame timeout", busy, 0);
    if (mode == 1) chk("stall seen", stalled, 1);
    tx_ready = 1;
  endtask
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray byte: got %0h want none", tx_data);
      end else begin
        chk("byte {fs,data}", {frame_start, tx_data}, q.pop_front());
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, gaps;
    repeat (2) @(posedge clk);
    #1;
    chk("reset tx_valid", tx_valid, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_start", frame_start, 0);
    chk("reset drop_count", drop_count, 0);
    rst = 1;
    @(posedge clk); #1;
    send(8'h04, 8'h13, 8'h05, 8'h05, 8'h00, 8'h00, 0, c);
    chk("basic cycles", c, 9);
    chk("basic busy", busy, 0);
    chk("basic drop_count", drop_count, 0);
    send(8'h04, 8'h13, 8'h05, 8'h05, 8'h00, 8'h00, 1, c);
    chk("backpressure busy", busy, 0);
    send(8'h04, 8'h13, 8'h05, 8'h05, 8'h00, 8'h00, 2, c);
    send(8'h44, 8'h13, 8'h05, 8'h05, 8'h00, 8'h00, 0, c);
    chk("pre-drop drop_count", drop_count, 0);
    repeat (3) push_frame(8'h04, 8'h13, 8'h05, 8'h05, 8'h00, 8'h00);
    set_in(8'h04, 8'h13, 8'h05, 8'h05, 8'h00, 8'h00);
    output_en = 1;
    gaps = 0;
    for (int k = 0; k < 27; k++) begin
      @(posedge clk); #1;
      if (!busy) gaps++;
    end
    output_en = 0;
    wait_idle(c);
    chk("b2b idle gaps", gaps, 0);
    chk("b2b tail cycles", c, 1);
    chk("b2b drop_count", drop_count, 24);
    chk("sat drop_count", s_drop, 4'hF);
    push_frame(8'h04, 8'h13, 8'h05, 8'h05, 8'h00, 8'h00);
    output_en = 1;
    @(posedge clk); #1;
    output_en = 0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("payload2 before reset", {tx_valid, tx_data}, {1'b1, 8'h05});
    #3 rst = 0;
    #1;
    chk("mid-reset tx_valid", tx_valid, 0);
    chk("mid-reset busy", busy, 0);
    chk("mid-reset drop_count", drop_count, 0);
    q.delete();
    exp_seq = 0;
    #2 rst = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 257; k++) begin
      send(8'(k), 8'h13, 8'(k * 3), 8'h05, 8'h00, 8'hC3, 0, c);
      if (k == 255) chk("seq ff frame cycles", c, 9);
    end
    chk("wrap drop_count", drop_count, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
